// File: rtl/demo_prog_loader.sv
// demo_prog_loader: stores IMAGES program images and shifts a selected one
// serially into a tiny processor's mode/sclk/mosi pins, then signals done.
// Optional feature macro: LOADER_CHECKSUM_EN appends a zero-sum checksum word.
module demo_prog_loader #(
    parameter int unsigned WORD_W     = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned IMAGES     = 2,
    parameter int unsigned HALF_DIV   = 2,
    parameter int unsigned GAP_CYCLES = 4,
    localparam int unsigned IMG_W     = (IMAGES > 1) ? $clog2(IMAGES) : 1,
    localparam int unsigned ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [IMG_W-1:0]  wr_img,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    output logic              wr_err,
    input  logic              start,
    input  logic [IMG_W-1:0]  img_sel,
    input  logic              pause,
    input  logic              abort,
    output logic [1:0]        mode_out,
    output logic              sclk_out,
    output logic              mosi_out,
    output logic              busy,
    output logic              done_out
);

`ifdef LOADER_CHECKSUM_EN
    localparam int unsigned N_WORDS = DEPTH + 1;
`else
    localparam int unsigned N_WORDS = DEPTH;
`endif
    localparam int unsigned WCNT_W = $clog2(N_WORDS + 1);
    localparam int unsigned BIT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int unsigned DIV_W  = $clog2(2 * HALF_DIV);
    localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    logic [WORD_W-1:0] mem [IMAGES][DEPTH];

    state_t            state_q, state_n;
    logic [IMG_W-1:0]  img_q, img_n;
    logic [WCNT_W-1:0] word_q, word_n;
    logic [BIT_W-1:0]  bit_q, bit_n;
    logic [DIV_W-1:0]  div_q, div_n;
    logic [GAP_W-1:0]  gap_q, gap_n;
    logic [WORD_W-1:0] shreg_q, shreg_n;
    logic [WORD_W-1:0] pre_q;
`ifdef LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] sum_q, sum_n;
`endif
    logic [1:0]        mode_n;
    logic              sclk_n, mosi_n, busy_n, done_n, wr_err_n;

    logic              idle_like_c, wr_ok_c;
    logic [IMG_W-1:0]  sel_img_c, rd_img_c;
    logic [ADDR_W-1:0] rd_addr_c;
    logic [WCNT_W-1:0] nxt_word_c;
    logic [WORD_W-1:0] rd_word_c;

    assign idle_like_c = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign sel_img_c   = (32'(img_sel) < IMAGES) ? img_sel : '0;
    assign nxt_word_c  = word_q + WCNT_W'(1);
    assign wr_ok_c     = wr_en && idle_like_c && (32'(wr_img) < IMAGES)
                         && (32'(wr_addr) < DEPTH);

    // Read port: word 0 of the selected image when idle, else the next word to prefetch
    always_comb begin
        rd_img_c  = img_q;
        rd_addr_c = '0;
        if (idle_like_c) begin
            rd_img_c = sel_img_c;
        end else if (32'(nxt_word_c) < DEPTH) begin
            rd_addr_c = ADDR_W'(nxt_word_c);
        end
    end

    assign rd_word_c = mem[rd_img_c][rd_addr_c];

    // Image memory write, only while no load is running
    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            mem[wr_img][wr_addr] <= wr_data;
        end
    end

    // Next-state, counters and output values; outputs follow the next state
    always_comb begin
        state_n  = state_q;
        img_n    = img_q;
        word_n   = word_q;
        bit_n    = bit_q;
        div_n    = div_q;
        gap_n    = gap_q;
        shreg_n  = shreg_q;
`ifdef LOADER_CHECKSUM_EN
        sum_n    = sum_q;
`endif
        wr_err_n = wr_en && !idle_like_c;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_n = ST_SHIFT;
                    img_n   = sel_img_c;
                    word_n  = '0;
                    bit_n   = BIT_W'(WORD_W - 1);
                    div_n   = '0;
                    gap_n   = '0;
                    shreg_n = rd_word_c;
`ifdef LOADER_CHECKSUM_EN
                    sum_n   = rd_word_c;
`endif
                end
            end
            ST_SHIFT: begin
                if (!pause) begin
                    if (div_q == DIV_W'(2 * HALF_DIV - 1)) begin
                        div_n = '0;
                        if (bit_q == '0) begin
                            if (word_q == WCNT_W'(N_WORDS - 1)) begin
                                state_n = ST_GAP;
                                gap_n   = '0;
                            end else begin
                                word_n = nxt_word_c;
                                bit_n  = BIT_W'(WORD_W - 1);
`ifdef LOADER_CHECKSUM_EN
                                if (32'(nxt_word_c) == DEPTH) begin
                                    shreg_n = ~sum_q + WORD_W'(1);
                                end else begin
                                    shreg_n = pre_q;
                                    sum_n   = sum_q + pre_q;
                                end
`else
                                shreg_n = pre_q;
`endif
                            end
                        end else begin
                            bit_n   = bit_q - BIT_W'(1);
                            shreg_n = {shreg_q[WORD_W-2:0], 1'b0};
                        end
                    end else begin
                        div_n = div_q + DIV_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (!pause) begin
                    if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                        state_n = ST_DONE;
                        gap_n   = '0;
                    end else begin
                        gap_n = gap_q + GAP_W'(1);
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (abort) begin
            state_n  = ST_IDLE;
            img_n    = '0;
            word_n   = '0;
            bit_n    = '0;
            div_n    = '0;
            gap_n    = '0;
            shreg_n  = '0;
`ifdef LOADER_CHECKSUM_EN
            sum_n    = '0;
`endif
            wr_err_n = 1'b0;
        end

        mode_n = 2'b00;
        if (state_n == ST_SHIFT || state_n == ST_GAP) begin
            mode_n = 2'b01;
        end else if (state_n == ST_DONE) begin
            mode_n = 2'b10;
        end
        sclk_n = (state_n == ST_SHIFT) && (div_n >= DIV_W'(HALF_DIV));
        mosi_n = (state_n == ST_SHIFT) && shreg_n[WORD_W-1];
        busy_n = (state_n == ST_SHIFT) || (state_n == ST_GAP);
        done_n = (state_n == ST_DONE);
    end

    // State, counters, prefetch buffer and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            img_q    <= '0;
            word_q   <= '0;
            bit_q    <= '0;
            div_q    <= '0;
            gap_q    <= '0;
            shreg_q  <= '0;
            pre_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q    <= '0;
`endif
            mode_out <= 2'b00;
            sclk_out <= 1'b0;
            mosi_out <= 1'b0;
            busy     <= 1'b0;
            done_out <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            state_q  <= state_n;
            img_q    <= img_n;
            word_q   <= word_n;
            bit_q    <= bit_n;
            div_q    <= div_n;
            gap_q    <= gap_n;
            shreg_q  <= shreg_n;
            if (state_q == ST_SHIFT) begin
                pre_q <= rd_word_c;
            end
`ifdef LOADER_CHECKSUM_EN
            sum_q    <= sum_n;
`endif
            mode_out <= mode_n;
            sclk_out <= sclk_n;
            mosi_out <= mosi_n;
            busy     <= busy_n;
            done_out <= done_n;
            wr_err   <= wr_err_n;
        end
    end

endmodule

// File: tb/tb_demo_prog_loader.sv
// Scoreboard bench for demo_prog_loader: expected serial bits are queued when a
// load is issued and popped by a monitor on every sclk rising edge.
module tb_demo_prog_loader;

    localparam int unsigned WORD_W     = 8;
    localparam int unsigned DEPTH      = 4;
    localparam int unsigned IMAGES     = 2;
    localparam int unsigned HALF_DIV   = 2;
    localparam int unsigned GAP_CYCLES = 4;
`ifdef LOADER_CHECKSUM_EN
    localparam int LOAD_CYCLES = 164;   // 5 words * 32 + 4
    localparam int SCLK_EDGES  = 40;
`else
    localparam int LOAD_CYCLES = 132;   // 4 words * 32 + 4
    localparam int SCLK_EDGES  = 32;
`endif
    localparam int NEVER = 100000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [0:0] wr_img = '0;
    logic [1:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       wr_err;
    logic       start = 1'b0;
    logic [0:0] img_sel = '0;
    logic       pause = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] mode_out;
    logic       sclk_out, mosi_out, busy, done_out;

    demo_prog_loader #(
        .WORD_W(WORD_W), .DEPTH(DEPTH), .IMAGES(IMAGES),
        .HALF_DIV(HALF_DIV), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_img(wr_img), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(wr_err),
        .start(start), .img_sel(img_sel), .pause(pause), .abort(abort),
        .mode_out(mode_out), .sclk_out(sclk_out), .mosi_out(mosi_out),
        .busy(busy), .done_out(done_out)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    int         edge_cnt = 0;
    bit         exp_q[$];
    logic [7:0] img_model [2][4];
    logic [7:0] csum_model [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) exp_q.push_back(w[i]);
    endtask

    task automatic push_image(input int sel);
        for (int w = 0; w < 4; w++) push_word(img_model[sel][w]);
`ifdef LOADER_CHECKSUM_EN
        push_word(csum_model[sel]);
`endif
    endtask

    task automatic write_word(input int img, input int addr, input logic [7:0] data);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_img = 1'(img); wr_addr = 2'(addr); wr_data = data;
        @(posedge clk); #1;
        wr_en = 1'b0;
        chk("wr_err_idle", 32'(wr_err), 32'd0);
    endtask

    // Issue a load and follow it cycle by cycle; n counts clk edges after SHIFT entry
    task automatic run_load(input int sel, input int pause_at, input int pause_len,
                            input int wr_at, input int abort_at, input int exp_cycles);
        int   n;
        logic snap_s, snap_m;
        edge_cnt = 0;
        push_image(sel);
        @(posedge clk); #1;
        start = 1'b1; img_sel = 1'(sel);
        @(posedge clk); #1;
        start = 1'b0;
        chk("mode_load", 32'(mode_out), 32'd1);
        chk("busy_load", 32'(busy), 32'd1);
        chk("done_low_load", 32'(done_out), 32'd0);
        n = 0;
        snap_s = 1'b0; snap_m = 1'b0;
        while (n < exp_cycles + 50) begin
            @(posedge clk); #1;
            n++;
            if (n == wr_at) begin
                wr_en = 1'b1; wr_img = 1'b0; wr_addr = 2'd0; wr_data = 8'h77;
            end
            if (n == wr_at + 1) begin
                chk("wr_err_pulse", 32'(wr_err), 32'd1);
                wr_en = 1'b0;
            end
            if (n == wr_at + 2) chk("wr_err_clear", 32'(wr_err), 32'd0);
            if (n == pause_at) begin
                snap_s = sclk_out; snap_m = mosi_out;
                pause = 1'b1;
            end
            if (n == pause_at + pause_len) begin
                chk("pause_sclk_hold", 32'(sclk_out), 32'(snap_s));
                chk("pause_mosi_hold", 32'(mosi_out), 32'(snap_m));
                pause = 1'b0;
            end
            if (n == abort_at) begin
                abort = 1'b1; start = 1'b1;
            end
            if (n == abort_at + 1) begin
                abort = 1'b0; start = 1'b0;
                chk("abort_mode", 32'(mode_out), 32'd0);
                chk("abort_sclk", 32'(sclk_out), 32'd0);
                chk("abort_mosi", 32'(mosi_out), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_done", 32'(done_out), 32'd0);
                exp_q.delete();
                @(posedge clk); #1;
                chk("abort_stays_idle", 32'(mode_out), 32'd0);
                return;
            end
            if (done_out) break;
        end
        chk("done_cycle", 32'(n), 32'(exp_cycles));
        chk("mode_run", 32'(mode_out), 32'd2);
        chk("busy_done", 32'(busy), 32'd0);
        chk("sclk_edges", 32'(edge_cnt), 32'(SCLK_EDGES));
        chk("stream_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: pop one expected bit per sclk rising edge and compare mosi
    initial begin : monitor
        logic prev;
        bit   b;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (sclk_out && !prev) begin
                edge_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL mosi_unexpected: got sclk edge with mosi %0b, expected no edge at %0t",
                             mosi_out, $time);
                end else begin
                    b = exp_q.pop_front();
                    chk("mosi_bit", 32'(mosi_out), 32'(b));
                end
            end
            prev = sclk_out;
        end
    end

    // Runaway guard
    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no end of test, expected finish within 400000 time units");
        $fatal(1);
    end

    initial begin : stimulus
        img_model[0][0] = 8'hA5; img_model[0][1] = 8'h3C;
        img_model[0][2] = 8'hFF; img_model[0][3] = 8'h00;
        img_model[1][0] = 8'h01; img_model[1][1] = 8'h02;
        img_model[1][2] = 8'h03; img_model[1][3] = 8'h04;
        csum_model[0] = 8'h20;   // -(A5+3C+FF+00) mod 256
        csum_model[1] = 8'hF6;   // -(01+02+03+04) mod 256

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mode", 32'(mode_out), 32'd0);
        chk("rst_sclk", 32'(sclk_out), 32'd0);
        chk("rst_mosi", 32'(mosi_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done_out), 32'd0);
        chk("rst_wr_err", 32'(wr_err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_mode", 32'(mode_out), 32'd0);

        for (int i = 0; i < 4; i++) write_word(0, i, img_model[0][i]);
        for (int i = 0; i < 4; i++) write_word(1, i, img_model[1][i]);

        // basic load of image 0
        run_load(0, NEVER, 0, NEVER, NEVER, LOAD_CYCLES);
        // image select, then image 0 again
        run_load(1, NEVER, 0, NEVER, NEVER, LOAD_CYCLES);
        // write while busy is rejected and does not alter image 0
        run_load(0, NEVER, 0, 10, NEVER, LOAD_CYCLES);
        run_load(0, NEVER, 0, NEVER, NEVER, LOAD_CYCLES);
        // pause 10 cycles inside word 1
        run_load(0, 42, 10, NEVER, NEVER, LOAD_CYCLES + 10);
        // abort inside word 2 together with start
        run_load(0, NEVER, 0, NEVER, 70, LOAD_CYCLES);
        // full stream after abort
        run_load(0, NEVER, 0, NEVER, NEVER, LOAD_CYCLES);

        repeat (3) @(posedge clk);
        #1;
        chk("done_held", 32'(done_out), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
